// File: rtl/sdram_wbuf.sv
// sdram_wbuf: posted-write FIFO and read sequencer in front of the SDRAM controller.
// Define WBUF_FWD_EN to let reads that hit a queued write return from the FIFO.
module sdram_wbuf #(
  parameter logic [15:0] BASE  = 16'h4C00,
  parameter int          DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        ready,
  output logic [23:0] sd_addr,
  output logic [15:0] sd_wdata,
  output logic        sd_read,
  output logic        sd_write,
  input  logic [15:0] sd_rdata,
  input  logic        sd_busy,
  input  logic        sd_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_W,
    WAIT_W,
    RD_ISSUE,
    RD_WAIT,
    RD_DONE
  } state_t;

  state_t state;

  logic [15:0]   fa [DEPTH];
  logic [15:0]   fd [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          pushed;
  logic          seen_busy;

  logic [15:0] raddr;
  logic        full;
  logic        empty;
  logic        wr_pend;
  logic        push;
  logic        pop;
  logic        rd_go;
  logic        fwd_go;
  logic [15:0] fwd_data;

  assign raddr   = addr - BASE;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  // A held wr that was already queued no longer counts as pending.
  assign wr_pend = wr && !pushed;
  assign push    = wr_pend && !full;
  assign pop     = (state == IDLE) && !empty && !sd_busy;
  assign rd_go   = (state == IDLE) && rd && empty && !wr_pend
                   && !sd_busy && !ready;
  assign busy    = !rst && ((rd && !ready) || (wr_pend && full));

`ifdef WBUF_FWD_EN
  logic hit;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && fa[rptr + AW'(i)] == raddr) begin
        hit      = 1'b1;
        fwd_data = fd[rptr + AW'(i)];
      end
    end
  end

  assign fwd_go = rd && hit && !wr_pend && !ready
                  && (state == IDLE || state == ISSUE_W || state == WAIT_W);
`else
  assign fwd_go   = 1'b0;
  assign fwd_data = '0;
`endif

  // FIFO storage; contents need no reset since count guards them.
  always_ff @(posedge clk) begin
    if (push) begin
      fa[wptr] <= raddr;
      fd[wptr] <= wdata;
    end
  end

  // Pointers, occupancy and the push-once flag for a held wr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      pushed <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      pushed <= wr && (pushed || push);
    end
  end

  // Drain and read sequencer; all bus-side outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      seen_busy <= 1'b0;
      sd_write  <= 1'b0;
      sd_read   <= 1'b0;
      ready     <= 1'b0;
      rdata     <= '0;
      sd_addr   <= '0;
      sd_wdata  <= '0;
    end else begin
      sd_write <= 1'b0;
      sd_read  <= 1'b0;
      ready    <= 1'b0;
      if (fwd_go) begin
        ready <= 1'b1;
        rdata <= fwd_data;
      end
      unique case (state)
        IDLE: begin
          if (pop) begin
            sd_write <= 1'b1;
            sd_addr  <= {8'h00, fa[rptr]};
            sd_wdata <= fd[rptr];
            state    <= ISSUE_W;
          end else if (rd_go) begin
            sd_read <= 1'b1;
            sd_addr <= {8'h00, raddr};
            state   <= RD_ISSUE;
          end
        end
        ISSUE_W: begin
          seen_busy <= 1'b0;
          state     <= WAIT_W;
        end
        WAIT_W: begin
          if (sd_busy)        seen_busy <= 1'b1;
          else if (seen_busy) state     <= IDLE;
        end
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT: begin
          if (sd_ready) begin
            rdata <= sd_rdata;
            ready <= 1'b1;
            state <= RD_DONE;
          end
        end
        RD_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wbuf.sv
// tb_sdram_wbuf: scoreboard bench for sdram_wbuf with a behavioural SDRAM.
// Build with WBUF_FWD_EN defined to exercise read forwarding as well.
module tb_sdram_wbuf;

  localparam logic [15:0] BASE  = 16'h4C00;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        rd;
  logic        wr;
  logic [15:0] rdata;
  logic        busy;
  logic        ready;
  logic [23:0] sd_addr;
  logic [15:0] sd_wdata;
  logic        sd_read;
  logic        sd_write;
  logic [15:0] sd_rdata;
  logic        sd_busy;
  logic        sd_ready;

  sdram_wbuf #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .rd(rd), .wr(wr), .rdata(rdata), .busy(busy), .ready(ready),
    .sd_addr(sd_addr), .sd_wdata(sd_wdata),
    .sd_read(sd_read), .sd_write(sd_write),
    .sd_rdata(sd_rdata), .sd_busy(sd_busy), .sd_ready(sd_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int nwrites = 0;

  logic [39:0] exp_wq[$];
  logic [23:0] exp_raddr[$];
  logic [15:0] exp_rq[$];
  logic [15:0] ref_mem[256];

  int   lat = 3;
  bit   stuck = 1'b0;
  int   left;
  bit   rpend;
  logic [7:0]  rsaddr;
  logic [15:0] sdmem[256];
  bit   mem_init = 1'b0;
  logic prev_ready = 1'b0;

  function automatic logic [15:0] init_val(input int i);
    return 16'(i) ^ 16'hA500;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // SDRAM storage: filled with a known pattern on the first edge.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) sdmem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (sd_write && !rst) begin
      sdmem[sd_addr[7:0]] <= sd_wdata;
    end
  end

  // SDRAM controller: busy for lat cycles per command, read data at end.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      left     <= 0;
      rpend    <= 1'b0;
      rsaddr   <= '0;
      sd_busy  <= 1'b0;
      sd_ready <= 1'b0;
      sd_rdata <= '0;
    end else begin
      sd_ready <= 1'b0;
      if (sd_write) begin
        left <= lat;
      end else if (sd_read) begin
        left   <= lat;
        rpend  <= 1'b1;
        rsaddr <= sd_addr[7:0];
      end else if (left > 1) begin
        left <= left - 1;
      end else if (left == 1) begin
        left <= 0;
        if (rpend) begin
          rpend    <= 1'b0;
          sd_ready <= 1'b1;
          sd_rdata <= sdmem[rsaddr];
        end
      end
      sd_busy <= stuck || sd_write || sd_read || left > 1;
    end
  end

  // Monitor: every DUT bus event is matched against the queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (sd_write) begin
        nwrites++;
        if (exp_wq.size() == 0) unexpected("spurious_sd_write");
        else check("sd_write", {sd_addr, sd_wdata}, exp_wq.pop_front());
      end
      if (sd_read) begin
        check("read_after_writes", exp_wq.size(), 0);
        if (exp_raddr.size() == 0) unexpected("spurious_sd_read");
        else check("sd_read_addr", sd_addr, exp_raddr.pop_front());
      end
      if (ready) begin
        check("ready_pulse", prev_ready, 0);
        if (exp_rq.size() == 0) unexpected("spurious_ready");
        else check("rdata", rdata, exp_rq.pop_front());
      end
      prev_ready = ready;
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_wq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_wq.size() != 0) unexpected("drain_timeout");
    repeat (lat + 6) @(posedge clk);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d,
                           output bit stalled);
    int n;
    logic [15:0] ra;
    @(posedge clk);
    #1;
    wr = 1'b1;
    addr = a;
    wdata = d;
    stalled = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      stalled = 1'b1;
      n++;
      @(negedge clk);
    end
    if (busy) unexpected("write_accept_timeout");
    ra = a - BASE;
    exp_wq.push_back({8'h00, ra, d});
    ref_mem[ra[7:0]] = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input bit fwd);
    int n;
    logic [15:0] ra;
`ifdef WBUF_FWD_EN
    if (!fwd) wait_drain();
`endif
    ra = a - BASE;
    exp_rq.push_back(ref_mem[ra[7:0]]);
    if (!fwd) exp_raddr.push_back({8'h00, ra});
    @(posedge clk);
    #1;
    rd = 1'b1;
    addr = a;
    @(negedge clk);
    check("read_busy", busy, 1);
    n = 0;
    while (!ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!ready) unexpected("read_timeout");
    else check("ready_unbusy", busy, 0);
    if (fwd) check("fwd_latency", n, 1);
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_sd_read"}, sd_read, 0);
    check({tag, "_sd_write"}, sd_write, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_sd_addr"}, sd_addr, 0);
    check({tag, "_sd_wdata"}, sd_wdata, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit st;
    int n;
    int n0;
    rst = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
    addr = '0;
    wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a drain discards the queue.
    lat = 4;
    cpu_write(16'h4CF0, 16'hAAAA, st);
    cpu_write(16'h4CF1, 16'hBBBB, st);
    cpu_write(16'h4CF2, 16'hCCCC, st);
    n = 0;
    while (nwrites == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_started", nwrites > 0, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    exp_wq.delete();
    exp_raddr.delete();
    exp_rq.delete();
    n0 = nwrites;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    check("no_write_after_rst", nwrites - n0, 0);

    // Three posted writes never stall the CPU.
    lat = 3;
    for (int i = 0; i < 3; i++) begin
      cpu_write(BASE + 16'(i), 16'h1111 * 16'(i + 1), st);
      check("post3_no_busy", st, 0);
    end
    wait_drain();

    // Full FIFO stalls the fifth write until the first pop.
    stuck = 1'b1;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      cpu_write(16'h4C08 + 16'(i), 16'($urandom), st);
      check("fill_no_busy", st, 0);
    end
    fork
      cpu_write(16'h4C0C, 16'h5555, st);
      begin
        repeat (4) @(posedge clk);
        #1;
        stuck = 1'b0;
      end
    join
    check("fifth_stalled", st, 1);
    wait_drain();

    // Read immediately behind a write to the same address.
    lat = 2;
    cpu_write(16'h4C10, 16'hBEEF, st);
    cpu_read(16'h4C10, 1'b0);

    // Ten back-to-back writes wrap the pointers with fast drains.
    lat = 1;
    for (int i = 0; i < 10; i++)
      cpu_write(16'h4C30 + 16'(i), 16'($urandom), st);
    cpu_read(16'h4C30, 1'b0);
    cpu_read(16'h4C39, 1'b0);

`ifdef WBUF_FWD_EN
    // Forwarded read returns the youngest queued value with no SDRAM access.
    wait_drain();
    stuck = 1'b1;
    repeat (3) @(posedge clk);
    cpu_write(16'h4C20, 16'h1234, st);
    cpu_write(16'h4C20, 16'h5678, st);
    cpu_read(16'h4C20, 1'b1);
    stuck = 1'b0;
    wait_drain();
    cpu_read(16'h4C20, 1'b0);
`endif

    // Randomised mix checked against the reference memory.
    for (int k = 0; k < 80; k++) begin
      logic [15:0] a;
      a = BASE + 16'($urandom_range(0, 15));
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 2) != 0) cpu_write(a, 16'($urandom), st);
      else cpu_read(a, 1'b0);
    end

    wait_drain();
    check("end_wq_empty", exp_wq.size(), 0);
    check("end_rq_empty", exp_rq.size(), 0);
    check("end_raddr_empty", exp_raddr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
